stage1_fetch_top: RTL and testbench
===================================

STAGE1_FETCH_TOP -- requirements
Module: stage1_fetch_top

Interface
REQ-001 Parameter: width, default 8, pixel data width in bits.
REQ-002 Parameter: IMG_DIM, default 32, square image side in pixels; IMG_DIM*IMG_DIM SHALL be <= 1024.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  launch request, sampled on clk in IDLE only.
REQ-006 wren  output  1  pixel-memory write enable.
REQ-007 addr  output  10  pixel-memory read address, row-major, addr = row*IMG_DIM + col.
REQ-008 data  input  width  pixel read from memory, valid one cycle after its address.
REQ-009 op1..op9  output  width each  3x3 window taps, row-major (op1 = top-left, op9 = bottom-right).
REQ-010 op1_valid..op9_valid  output  1 each  high while the matching opN carries a tap.
REQ-011 op_NoConnect  output  width  default route for data when no tap is selected.

Function
REQ-012 SHALL comprise a control unit generating addr and a 4-bit tap select, plus a combinational 1-to-9 demux steered by that select.
REQ-013 Control FSM states: IDLE, FETCH, DONE; IDLE->FETCH on start=1; FETCH->DONE after tap 8 of the last window; DONE->IDLE after exactly one cycle.
REQ-014 start SHALL be ignored in FETCH and DONE.
REQ-015 Windows SHALL be visited row-major: top-left (r,c), r and c in 0..IMG_DIM-3, c incrementing fastest; 900 windows at IMG_DIM=32.
REQ-016 Per window, taps t=0..8 SHALL be issued one per cycle: addr = (r + t/3)*IMG_DIM + c + t%3; no idle cycles between windows.
REQ-017 On the edge entering FETCH, addr SHALL become the tap-0 address of window (0,0).
REQ-018 Tap select SHALL be registered: select = t+1 in the cycle after tap t's address is driven; select = 0 otherwise, including in IDLE and on return to IDLE.
REQ-019 Demux: for select N in 1..9, opN = data and opN_valid = 1; all other op outputs 0 and valids 0.
REQ-020 For select 0 or 10..15, all opN and opN_valid SHALL be 0 and op_NoConnect = data (see REQ-026).
REQ-021 wren SHALL be 0 at all times (read-only stage).
REQ-022 addr SHALL hold its last value in DONE and IDLE.
REQ-023 Total FETCH duration SHALL be 9*(IMG_DIM-2)^2 cycles (8100 at default).

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, addr=0, select=0, window and tap counters=0, wren=0, all opN_valid=0.
REQ-025 Reset mid-FETCH SHALL abort the scan; the next start SHALL restart at window (0,0) tap 0.

Configuration
REQ-026 Macro STAGE1_NOCONNECT_EN: when defined, op_NoConnect = data for unselected cases per REQ-020; when undefined, op_NoConnect SHALL be tied to 0.

Verification
REQ-027 Assert rst for 1 cycle -> addr=0, all opN_valid=0, wren=0, all opN=0, op_NoConnect=data (macro defined).
REQ-028 Pulse start for one cycle -> addr sequence 0,1,2,32,33,34,64,65,66 on consecutive cycles; op1_valid..op9_valid each high for one cycle, each one cycle after its address.
REQ-029 With data=8'd123 constant -> op1..op9 each read 123 only in their valid cycle; 0 otherwise.
REQ-030 Second window -> addresses 1,2,3,33,34,35,65,66,67; last window -> 957,958,959,989,990,991,1021,1022,1023, then DONE one cycle, then IDLE.
REQ-031 Pulse start again mid-FETCH -> no disturbance to address sequence; assert rst mid-FETCH -> outputs per REQ-024, fresh start resumes at address 0.
REQ-032 Build without STAGE1_NOCONNECT_EN, IDLE with data=8'd123 -> op_NoConnect=0.

Source files
------------

// File: rtl/stage1_fetch_top.sv
// Stage-1 pixel fetch: scans every 3x3 window of an IMG_DIM x IMG_DIM image and steers pixels onto nine tap outputs.
// Build option: define STAGE1_NOCONNECT_EN to route data onto op_NoConnect when no tap is selected.
module stage1_fetch_top #(
  parameter int width   = 8,
  parameter int IMG_DIM = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             wren,
  output logic [9:0]       addr,
  input  logic [width-1:0] data,
  output logic [width-1:0] op1,
  output logic [width-1:0] op2,
  output logic [width-1:0] op3,
  output logic [width-1:0] op4,
  output logic [width-1:0] op5,
  output logic [width-1:0] op6,
  output logic [width-1:0] op7,
  output logic [width-1:0] op8,
  output logic [width-1:0] op9,
  output logic             op1_valid,
  output logic             op2_valid,
  output logic             op3_valid,
  output logic             op4_valid,
  output logic             op5_valid,
  output logic             op6_valid,
  output logic             op7_valid,
  output logic             op8_valid,
  output logic             op9_valid,
  output logic [width-1:0] op_NoConnect
);

  // state | meaning
  // IDLE  | waiting for start, addr holds
  // FETCH | issuing one tap address per cycle
  // DONE  | one cycle after the last tap, then back to IDLE
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  localparam logic [9:0] DIM  = 10'(IMG_DIM);
  localparam logic [9:0] LAST = 10'(IMG_DIM - 3);

  state_t     state_q, state_d;
  logic [9:0] row_q, row_d, col_q, col_d;
  logic [1:0] trow_q, trow_d, tcol_q, tcol_d;
  logic [9:0] addr_q, addr_d;
  logic [3:0] sel_q, sel_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    trow_d  = trow_q;
    tcol_d  = tcol_q;
    addr_d  = addr_q;
    sel_d   = 4'd0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          row_d   = '0;
          col_d   = '0;
          trow_d  = '0;
          tcol_d  = '0;
          addr_d  = '0;
        end
      end
      FETCH: begin
        sel_d = 4'(trow_q) * 4'd3 + 4'(tcol_q) + 4'd1;
        if (tcol_q != 2'd2) begin
          tcol_d = tcol_q + 2'd1;
        end else if (trow_q != 2'd2) begin
          tcol_d = 2'd0;
          trow_d = trow_q + 2'd1;
        end else begin
          tcol_d = 2'd0;
          trow_d = 2'd0;
          if (col_q != LAST) begin
            col_d = col_q + 10'd1;
          end else if (row_q != LAST) begin
            col_d = '0;
            row_d = row_q + 10'd1;
          end else begin
            state_d = DONE;
          end
        end
        // On the final tap addr is left alone so it holds through DONE and IDLE.
        if (state_d == FETCH)
          addr_d = (row_d + 10'(trow_d)) * DIM + col_d + 10'(tcol_d);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      trow_q  <= '0;
      tcol_q  <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      trow_q  <= trow_d;
      tcol_q  <= tcol_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
    end
  end

  logic       hit;
  logic [8:0] vld;
  assign hit  = (sel_q >= 4'd1) && (sel_q <= 4'd9);
  assign vld  = hit ? (9'd1 << (sel_q - 4'd1)) : 9'd0;
  assign addr = addr_q;
  assign wren = 1'b0;

  assign op1_valid = vld[0];
  assign op2_valid = vld[1];
  assign op3_valid = vld[2];
  assign op4_valid = vld[3];
  assign op5_valid = vld[4];
  assign op6_valid = vld[5];
  assign op7_valid = vld[6];
  assign op8_valid = vld[7];
  assign op9_valid = vld[8];

  assign op1 = vld[0] ? data : '0;
  assign op2 = vld[1] ? data : '0;
  assign op3 = vld[2] ? data : '0;
  assign op4 = vld[3] ? data : '0;
  assign op5 = vld[4] ? data : '0;
  assign op6 = vld[5] ? data : '0;
  assign op7 = vld[6] ? data : '0;
  assign op8 = vld[7] ? data : '0;
  assign op9 = vld[8] ? data : '0;

`ifdef STAGE1_NOCONNECT_EN
  assign op_NoConnect = hit ? '0 : data;
`else
  assign op_NoConnect = '0;
`endif

endmodule

// File: tb/tb_stage1_fetch_top.sv
// Randomized bench for stage1_fetch_top against an index-based model of the window scan.
module tb_stage1_fetch_top;
  localparam int W = 8;
  localparam int D = 32;
  localparam int N = D - 2;
  localparam int TOTAL = 9 * N * N;

  logic         clk = 1'b0;
  logic         rst, start;
  logic         wren;
  logic [9:0]   addr;
  logic [W-1:0] data;
  logic [W-1:0] op1, op2, op3, op4, op5, op6, op7, op8, op9, op_nc;
  logic         v1, v2, v3, v4, v5, v6, v7, v8, v9;

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 fetch, 2 done
  int m_phase, m_k, m_addr, m_sel;

  stage1_fetch_top #(.width(W), .IMG_DIM(D)) dut (
    .clk(clk), .rst(rst), .start(start), .wren(wren), .addr(addr), .data(data),
    .op1(op1), .op2(op2), .op3(op3), .op4(op4), .op5(op5), .op6(op6), .op7(op7), .op8(op8), .op9(op9),
    .op1_valid(v1), .op2_valid(v2), .op3_valid(v3), .op4_valid(v4), .op5_valid(v5),
    .op6_valid(v6), .op7_valid(v7), .op8_valid(v8), .op9_valid(v9),
    .op_NoConnect(op_nc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int addr_of(input int k);
    int w, t;
    w = k / 9;
    t = k % 9;
    return ((w / N) + t / 3) * D + (w % N) + t % 3;
  endfunction

  task automatic check_outputs();
    logic [71:0] exp_ops;
    logic [8:0]  exp_vld;
    logic [W-1:0] exp_nc;
    exp_ops = '0;
    exp_vld = '0;
    exp_nc  = '0;
    if (m_sel >= 1 && m_sel <= 9) begin
      exp_ops[(9 - m_sel) * W +: W] = data;
      exp_vld[9 - m_sel] = 1'b1;
    end else begin
`ifdef STAGE1_NOCONNECT_EN
      exp_nc = data;
`endif
    end
    chk("addr", 128'(addr), 128'(m_addr));
    chk("wren", 128'(wren), 128'(0));
    chk("valids", 128'({v1, v2, v3, v4, v5, v6, v7, v8, v9}), 128'(exp_vld));
    chk("ops", 128'({op1, op2, op3, op4, op5, op6, op7, op8, op9}), 128'(exp_ops));
    chk("noconnect", 128'(op_nc), 128'(exp_nc));
  endtask

  task automatic model_reset();
    m_phase = 0; m_k = 0; m_addr = 0; m_sel = 0;
  endtask

  // One clock: model absorbs the edge, then new inputs are driven and outputs checked.
  task automatic step(input logic st_next);
    @(posedge clk);
    case (m_phase)
      0: if (start) begin m_phase = 1; m_k = 0; m_addr = addr_of(0); end
      1: begin
        m_sel = (m_k % 9) + 1;
        if (m_k == TOTAL - 1) m_phase = 2;
        else begin m_k++; m_addr = addr_of(m_k); end
      end
      default: begin m_sel = 0; m_phase = 0; end
    endcase
    if (m_phase != 1) m_sel = (m_phase == 2) ? m_sel : 0;
    @(negedge clk);
    start = st_next;
    data  = W'($urandom);
    #1 check_outputs();
  endtask

  task automatic run_to_idle(input string tag);
    int n;
    n = 0;
    while (m_phase != 0 && n < TOTAL + 20) begin
      step((m_phase == 1) ? ($urandom_range(3) == 0) : 1'b0);
      n++;
    end
    chk(tag, 128'(m_phase), 128'(0));
  endtask

  initial begin
    int cut;
    rst = 1'b1; start = 1'b0; data = 8'd123;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_outputs();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0);
    step(1'b1);
    step(1'b0);
    run_to_idle("scan1_done");
    for (int i = 0; i < 3; i++) step(1'b0);
    chk("addr_hold_idle", 128'(addr), 128'(addr_of(TOTAL - 1)));

    step(1'b1);
    step(1'b0);
    cut = $urandom_range(3000, 100);
    for (int i = 0; i < cut; i++) step(($urandom_range(3) == 0) ? 1'b1 : 1'b0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1 check_outputs();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    #1 check_outputs();
    step(1'b1);
    step(1'b0);
    chk("restart_addr0", 128'(addr), 128'(0));
    run_to_idle("scan2_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
